// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared controller state type and default sizes for sp_ram_ctrl.
package sp_ram_pkg;
    typedef enum logic {CLEAR, RUN} ctrl_state_t;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int RSP_DEPTH = 2;
endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// sp_ram_rsp_fifo: small synchronous response FIFO; DEPTH must be a power of two.
module sp_ram_rsp_fifo
    import sp_ram_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int DEPTH = RSP_DEPTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop = pop && count_q != '0;
        do_push = push && (count_q != CW'(DEPTH) || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d = wr_q + PW'(do_push);
        rd_d = rd_q + PW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head = mem_q[rd_q];
endmodule

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: valid/ready command front end for a read-first single-port RAM.
// Define SP_RAM_CTRL_CLEAR_EN to zero every RAM word after reset.
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_qout
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          clr, accept, credit, pop, inflight_q, inflight_d;
    logic [AW-1:0] clr_addr;
    logic [CW-1:0] count;
    logic [CW:0]   occ;

`ifdef SP_RAM_CTRL_CLEAR_EN
    ctrl_state_t state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = (state_q == CLEAR && cnt_q == {1'b0, {AW{1'b1}}}) ? RUN : state_q;
        cnt_d = (state_q == CLEAR) ? cnt_q + (AW + 1)'(1) : cnt_q;
    end

    assign clr = state_q == CLEAR;
    assign clr_addr = cnt_q[AW-1:0];
`else
    assign clr = 1'b0;
    assign clr_addr = '0;
`endif

    // A response popped this cycle frees its slot for a read accepted on the same edge.
    always_comb begin
        pop = rsp_valid && rsp_ready;
        occ = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
        credit = occ < (CW + 1)'(RSP_DEPTH);
        req_ready = !rst && !clr && (req_we || credit);
        accept = req_valid && req_ready;
        inflight_d = accept && !req_we;
        ram_we = !rst && (clr || (accept && req_we));
        ram_addr = clr ? clr_addr : (accept ? req_addr : '0);
        ram_din = (accept && req_we) ? req_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) inflight_q <= 1'b0;
        else inflight_q <= inflight_d;
    end

    sp_ram_rsp_fifo #(.DW(DW), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (ram_qout),
        .pop       (pop),
        .count     (count),
        .head      (rsp_rdata)
    );

    assign rsp_valid = count != '0;
    assign init_done = !clr;
endmodule
